// File: rtl/ntt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_sched_pkg
// Description : Shared opcodes and index helper for the NTT pass scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_sched_pkg;

    // Operation codes carried on op_in / opcode
    localparam logic [1:0] OP_NTT  = 2'b00;
    localparam logic [1:0] OP_INTT = 2'b01;
    localparam logic [1:0] OP_PWM0 = 2'b10;
    localparam logic [1:0] OP_PWM1 = 2'b11;

    // Beat and stage limits for a 256-point transform on two PEs
    localparam logic [5:0] LAST_BEAT  = 6'd63;
    localparam logic [2:0] STAGE_LAST = 3'd7;

    // Even-operand index of butterfly b in stage s.
    // The half-span is h = 2^(7-s); butterflies are grouped in runs of h,
    // each group covers 2h coefficients, and b mod h selects the position
    // inside the group. The odd operand is this value plus h.
    function automatic logic [7:0] bfly_even(input logic [6:0] b,
                                             input logic [2:0] s);
        logic [2:0] sh;
        logic [7:0] bw;
        logic [7:0] h;
        sh = 3'd7 - s;
        bw = {1'b0, b};
        h  = 8'd1 << sh;
        return ((bw >> sh) << ({1'b0, sh} + 4'd1)) + (bw & (h - 8'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_sched_idx_gen.sv
`default_nettype none
// ============================================================================
// Module      : ntt_idx_gen
// Description : Combinational generator of the four logical coefficient
//               indices (PE0/PE1 even/odd) for one scheduler beat.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_idx_gen
    import ntt_sched_pkg::*;
(
    input  logic [5:0] k_i,
    input  logic [2:0] stage_i,
    input  logic [1:0] opcode_i,
    output logic [7:0] ie0_o,
    output logic [7:0] io0_o,
    output logic [7:0] ie1_o,
    output logic [7:0] io1_o
);

    logic [7:0] w_h;
    logic       w_is_pwm;

    // Butterfly operands for NTT/INTT, four consecutive coefficients for PWM
    always_comb begin
        w_h      = 8'd1 << (3'd7 - stage_i);
        w_is_pwm = (opcode_i == OP_PWM0) || (opcode_i == OP_PWM1);
        if (w_is_pwm) begin
            ie0_o = {k_i, 2'b00};
            io0_o = {k_i, 2'b01};
            ie1_o = {k_i, 2'b10};
            io1_o = {k_i, 2'b11};
        end else begin
            ie0_o = bfly_even({k_i, 1'b0}, stage_i);
            io0_o = ie0_o + w_h;
            ie1_o = bfly_even({k_i, 1'b1}, stage_i);
            io1_o = ie1_o + w_h;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ntt_sched.sv
`default_nettype none
// ============================================================================
// Module      : ntt_sched
// Description : Pass scheduler for a two-PE NTT engine. Issues 64 beats per
//               pass, inserts DRAIN_CYC idle cycles after each pass, walks
//               the stages and ping-pong buffer select, pulses done.
//               DRAIN_CYC must be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_sched
    import ntt_sched_pkg::*;
#(
    parameter int DRAIN_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op_in,
    input  logic       base_off,
    input  logic       hold,
    output logic [1:0] opcode,
    output logic       mode,
    output logic       offset,
    output logic [7:0] old_ie0,
    output logic [7:0] old_io0,
    output logic [7:0] old_ie1,
    output logic [7:0] old_io1,
    output logic       issue_vld,
    output logic [2:0] stage,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int             DCW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    logic [1:0]     state_q,  state_d;
    logic [5:0]     k_q,      k_d;
    logic [2:0]     stage_q,  stage_d;
    logic [1:0]     opcode_q, opcode_d;
    logic           mode_q,   mode_d;
    logic           offset_q, offset_d;
    logic [DCW-1:0] drain_q,  drain_d;

    logic       w_last_beat;
    logic       w_drain_end;
    logic       w_last_pass;
    logic [7:0] w_ie0, w_io0, w_ie1, w_io1;

    assign w_last_beat = (k_q == LAST_BEAT);
    assign w_drain_end = (drain_q == DRAIN_LAST);
    // PWM is a single pass; NTT ends on stage 7, INTT on stage 0
    assign w_last_pass = (opcode_q == OP_PWM0) || (opcode_q == OP_PWM1) ||
                         ((opcode_q == OP_NTT)  && (stage_q == STAGE_LAST)) ||
                         ((opcode_q == OP_INTT) && (stage_q == 3'd0));

    ntt_idx_gen u_idx_gen (
        .k_i      (k_q),
        .stage_i  (stage_q),
        .opcode_i (opcode_q),
        .ie0_o    (w_ie0),
        .io0_o    (w_io0),
        .ie1_o    (w_ie1),
        .io1_o    (w_io1)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; hold freezes every state except IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!hold && w_last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!hold && w_drain_end) begin
                    state_d = w_last_pass ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (!hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: beat, stage, parity, buffer select, drain count
    always_comb begin
        k_d      = k_q;
        stage_d  = stage_q;
        opcode_d = opcode_q;
        mode_d   = mode_q;
        offset_d = offset_q;
        drain_d  = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opcode_d = op_in;
                    offset_d = base_off;
                    mode_d   = 1'b0;
                    k_d      = 6'd0;
                    drain_d  = '0;
                    stage_d  = (op_in == OP_INTT) ? STAGE_LAST : 3'd0;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    k_d     = k_q + 6'd1;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (!hold) begin
                    if (!w_drain_end) begin
                        drain_d = drain_q + 1'b1;
                    end else if (!w_last_pass) begin
                        k_d      = 6'd0;
                        mode_d   = ~mode_q;
                        offset_d = ~offset_q;
                        stage_d  = (opcode_q == OP_INTT) ? (stage_q - 3'd1)
                                                         : (stage_q + 3'd1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= 6'd0;
            stage_q  <= 3'd0;
            opcode_q <= 2'd0;
            mode_q   <= 1'b0;
            offset_q <= 1'b0;
            drain_q  <= '0;
        end else begin
            k_q      <= k_d;
            stage_q  <= stage_d;
            opcode_q <= opcode_d;
            mode_q   <= mode_d;
            offset_q <= offset_d;
            drain_q  <= drain_d;
        end
    end

    // Outputs; indices are forced to zero whenever no beat is being issued
    always_comb begin
        issue_vld = (state_q == S_RUN);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        opcode    = opcode_q;
        mode      = mode_q;
        offset    = offset_q;
        stage     = stage_q;
        old_ie0   = issue_vld ? w_ie0 : 8'd0;
        old_io0   = issue_vld ? w_io0 : 8'd0;
        old_ie1   = issue_vld ? w_ie1 : 8'd0;
        old_io1   = issue_vld ? w_io1 : 8'd0;
    end

endmodule
`default_nettype wire

// File: doc/ntt_sched.md
NTT_SCHED -- requirements
Module: ntt_sched

Interface
REQ-001 Parameter DRAIN_CYC, default 4: idle cycles inserted after each pass's last issue, covering map register plus PE pipeline.
REQ-002 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset is synchronous and active-high.
REQ-004 Port start, input, 1: single-cycle request to begin a transform; honoured only in IDLE.
REQ-005 Port op_in, input, 2: operation code, sampled with start (`NTT, `INTT, `PWM0, `PWM1).
REQ-006 Port base_off, input, 1: initial ping-pong buffer select, sampled with start.
REQ-007 Port hold, input, 1: stall; freezes all counters and outputs while high.
REQ-008 Port opcode, output, 2: latched operation code, driven to the address map.
REQ-009 Port mode, output, 1: pass parity, driven to the address map.
REQ-010 Port offset, output, 1: current source buffer select.
REQ-011 Ports old_ie0, old_io0, old_ie1, old_io1, output, 8 each: logical coefficient indices for PE0/PE1 even/odd operands.
REQ-012 Port issue_vld, output, 1: index outputs valid this cycle.
REQ-013 Port stage, output, 3: current pass number.
REQ-014 Ports busy and done, output, 1 each: busy high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, RUN, DRAIN, DONE; encoding is free.
REQ-016 IDLE->RUN on start; op_in and base_off latched; beat counter k=0; stage = 0 for NTT and PWM, 7 for INTT.
REQ-017 RUN SHALL issue one beat per cycle with hold low (issue_vld=1), k from 0 to 63.
REQ-018 NTT/INTT beat k, stage s: h=2^(7-s); for b=2k (PE0) and b=2k+1 (PE1): ie=(b>>(7-s))*2h+(b mod h), io=ie+h.
REQ-019 PWM0/PWM1 beat k: old_ie0=4k, old_io0=4k+1, old_ie1=4k+2, old_io1=4k+3.
REQ-020 All index arithmetic SHALL be 8-bit; no index exceeds 255.
REQ-021 RUN->DRAIN after the beat with k=63; issue_vld=0 throughout DRAIN.
REQ-022 DRAIN SHALL last DRAIN_CYC cycles, then:
- more passes remain: RUN, k=0, offset toggles, mode toggles;
- otherwise: DONE.
REQ-023 Pass count: 8 for NTT (stage 0..7 ascending), 8 for INTT (stage 7..0 descending), 1 for PWM0/PWM1.
REQ-024 mode SHALL be 0 on the first pass and toggle per pass; offset SHALL start at base_off and toggle per pass.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 With hold high, state, k, stage and all outputs SHALL remain unchanged; issue_vld also stays unchanged, and the consumer ignores beats while hold=1.
REQ-027 start outside IDLE SHALL be ignored; start and hold together in IDLE SHALL still be accepted.
REQ-028 Latency: first issue_vld in the cycle after start is sampled.
REQ-029 Total cycles from start to done with hold low:
- NTT/INTT: 8*(64+DRAIN_CYC)+1;
- PWM: 64+DRAIN_CYC+1.

Reset
REQ-030 On rst, the block SHALL reach IDLE with every output at 0 (opcode, mode, offset, indices, issue_vld, stage, busy, done).
REQ-031 rst SHALL take priority over start and hold, and SHALL abort any pass in progress without emitting done.

Structure
REQ-032 Opcode constants `NTT=2'b00, `INTT=2'b01, `PWM0=2'b10, `PWM1=2'b11 belong in parameter.v with the existing MAP constants; state encodings stay local.
REQ-033 One sub-module, ntt_idx_gen, SHALL be combinational (inputs k, stage, opcode; outputs the four indices); all registers live in ntt_sched.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- NTT, base_off=0, DRAIN_CYC=4:
  - first beat: ie0=0, io0=128, ie1=1, io1=129;
  - stage 7 beat 0: ie0=0, io0=1, ie1=2, io1=3;
  - done 545 cycles after start.
- INTT: first pass stage=7, offset=base_off; last pass stage=0 with mode=1.
- PWM1, base_off=1:
  - beat 63: ie0=252, io0=253, ie1=254, io1=255;
  - offset=1, mode=0 throughout;
  - done 69 cycles after start.
- hold asserted 3 cycles mid-RUN at k=10: outputs frozen, k=11 follows release, total cycle count +3.
- start pulsed during RUN: ignored; rst asserted during DRAIN: all outputs 0 next cycle, no done.
- Coverage across full NTT: every index 0..255 appears exactly once per stage.
